comp_acum_result: RTL and testbench

COMP_ACUM_RESULT -- requirements
Module: comp_acum_result

---
 rtl/comp_acum_result.sv | 136 +++++++++++++
 tb/tb_comp_acum_result.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/comp_acum_result.sv
// comp_acum_result: windowed accumulator of comparator results.
// Counts how many samples of a WIN-sample window were "mayor", "igual" or
// "menor" (one-hot flags from the upstream comparator), flags non-one-hot
// samples, and pulses o_Done one cycle after the last sample of the window.
//
// Ports:
//   i_Clk                  rising-edge clock
//   i_Rst                  synchronous active-high reset (wins over i_Start)
//   i_Start                starts a window (only honoured in IDLE)
//   i_Valid                the flag triple is a sample this cycle
//   i_Mayor/i_Igual/i_Menor comparator flags, expected one-hot
//   o_CntMayor/Igual/Menor per-class counts, saturating at 2^CW-1
//   o_Busy                 high while the window is being accumulated
//   o_Done                 one-cycle end-of-window pulse
//   o_Error                sticky: a sample was not one-hot
//   o_Mayoria              (only with COMP_ACUM_MAYORIA_EN) majority class
//                          01=mayor, 10=menor, 11=igual, 00=tie
//
// Optional feature macro: COMP_ACUM_MAYORIA_EN
module comp_acum_result #(
    parameter int CW  = 8,
    parameter int WIN = 16
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic          i_Start,
    input  logic          i_Valid,
    input  logic          i_Mayor,
    input  logic          i_Igual,
    input  logic          i_Menor,
    output logic [CW-1:0] o_CntMayor,
    output logic [CW-1:0] o_CntIgual,
    output logic [CW-1:0] o_CntMenor,
    output logic          o_Busy,
    output logic          o_Done,
`ifdef COMP_ACUM_MAYORIA_EN
    output logic          o_Error,
    output logic [1:0]    o_Mayoria
`else
    output logic          o_Error
`endif
);
    localparam int SW = $clog2(WIN + 1);

    typedef enum logic [1:0] {IDLE, CONT, FIN} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] smp, smp_nxt;
    logic [CW-1:0] may_nxt, igu_nxt, men_nxt;
    logic          err_nxt;
    logic          sample, last, one_hot;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    assign sample  = (state == CONT) && i_Valid;
    assign last    = sample && (smp == SW'(WIN - 1));
    assign one_hot = {i_Mayor, i_Igual, i_Menor} inside {3'b100, 3'b010, 3'b001};
    assign o_Busy  = (state == CONT);
    assign o_Done  = (state == FIN);

    always_comb begin
        state_nxt = state;
        smp_nxt   = smp;
        may_nxt   = o_CntMayor;
        igu_nxt   = o_CntIgual;
        men_nxt   = o_CntMenor;
        err_nxt   = o_Error;
        if (state == IDLE) begin
            if (i_Start) begin
                state_nxt = CONT;
                smp_nxt   = '0;
                may_nxt   = '0;
                igu_nxt   = '0;
                men_nxt   = '0;
                err_nxt   = 1'b0;
            end
        end else if (state == CONT) begin
            if (sample) begin
                smp_nxt   = smp + SW'(1);
                state_nxt = last ? FIN : CONT;
                if (one_hot) begin
                    may_nxt = i_Mayor ? sat_inc(o_CntMayor) : o_CntMayor;
                    igu_nxt = i_Igual ? sat_inc(o_CntIgual) : o_CntIgual;
                    men_nxt = i_Menor ? sat_inc(o_CntMenor) : o_CntMenor;
                end else begin
                    err_nxt = 1'b1;
                end
            end
        end else begin
            // FIN, and recovery from the unused encoding
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state      <= IDLE;
            smp        <= '0;
            o_CntMayor <= '0;
            o_CntIgual <= '0;
            o_CntMenor <= '0;
            o_Error    <= 1'b0;
        end else begin
            state      <= state_nxt;
            smp        <= smp_nxt;
            o_CntMayor <= may_nxt;
            o_CntIgual <= igu_nxt;
            o_CntMenor <= men_nxt;
            o_Error    <= err_nxt;
        end
    end

`ifdef COMP_ACUM_MAYORIA_EN
    // Strictly largest count wins; any tie for the top is reported as 00.
    function automatic logic [1:0] majority(input logic [CW-1:0] m, i, l);
        if (m > i && m > l) return 2'b01;
        if (l > m && l > i) return 2'b10;
        if (i > m && i > l) return 2'b11;
        return 2'b00;
    endfunction

    // Evaluated on the counts that include the final sample, so the value
    // is valid in the same cycle o_Done is high.
    always_ff @(posedge i_Clk) begin
        if (i_Rst)
            o_Mayoria <= 2'b00;
        else if (state == IDLE && i_Start)
            o_Mayoria <= 2'b00;
        else if (last)
            o_Mayoria <= majority(may_nxt, igu_nxt, men_nxt);
    end
`endif

endmodule

// File: tb/tb_comp_acum_result.sv
// tb_comp_acum_result: directed self-checking bench for comp_acum_result.
// Several instances with different CW/WIN share one stimulus bus; each test
// resets all of them and then checks the instance it targets.
module tb_comp_acum_result;
    logic i_Clk = 1'b0, i_Rst = 1'b0, i_Start = 1'b0, i_Valid = 1'b0;
    logic i_Mayor = 1'b0, i_Igual = 1'b0, i_Menor = 1'b0;

    logic [7:0] a_m, a_i, a_l, b_m, b_i, b_l, d_m, d_i, d_l, e_m, e_i, e_l;
    logic [1:0] c_m, c_i, c_l;
    logic a_busy, a_done, a_err, b_busy, b_done, b_err, c_busy, c_done, c_err;
    logic d_busy, d_done, d_err, e_busy, e_done, e_err;
`ifdef COMP_ACUM_MAYORIA_EN
    logic [1:0] a_may, b_may, c_may, d_may, e_may;
`endif

    int passed = 0;
    int total  = 0;

    always #5 i_Clk = ~i_Clk;

`ifdef COMP_ACUM_MAYORIA_EN
    comp_acum_result #(.CW(8), .WIN(4)) u_a (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Valid(i_Valid),
        .i_Mayor(i_Mayor), .i_Igual(i_Igual), .i_Menor(i_Menor), .o_CntMayor(a_m), .o_CntIgual(a_i),
        .o_CntMenor(a_l), .o_Busy(a_busy), .o_Done(a_done), .o_Error(a_err), .o_Mayoria(a_may));
    comp_acum_result #(.CW(8), .WIN(3)) u_b (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Valid(i_Valid),
        .i_Mayor(i_Mayor), .i_Igual(i_Igual), .i_Menor(i_Menor), .o_CntMayor(b_m), .o_CntIgual(b_i),
        .o_CntMenor(b_l), .o_Busy(b_busy), .o_Done(b_done), .o_Error(b_err), .o_Mayoria(b_may));
    comp_acum_result #(.CW(2), .WIN(5)) u_c (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Valid(i_Valid),
        .i_Mayor(i_Mayor), .i_Igual(i_Igual), .i_Menor(i_Menor), .o_CntMayor(c_m), .o_CntIgual(c_i),
        .o_CntMenor(c_l), .o_Busy(c_busy), .o_Done(c_done), .o_Error(c_err), .o_Mayoria(c_may));
    comp_acum_result #(.CW(8), .WIN(8)) u_d (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Valid(i_Valid),
        .i_Mayor(i_Mayor), .i_Igual(i_Igual), .i_Menor(i_Menor), .o_CntMayor(d_m), .o_CntIgual(d_i),
        .o_CntMenor(d_l), .o_Busy(d_busy), .o_Done(d_done), .o_Error(d_err), .o_Mayoria(d_may));
    comp_acum_result #(.CW(8), .WIN(1)) u_e (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Valid(i_Valid),
        .i_Mayor(i_Mayor), .i_Igual(i_Igual), .i_Menor(i_Menor), .o_CntMayor(e_m), .o_CntIgual(e_i),
        .o_CntMenor(e_l), .o_Busy(e_busy), .o_Done(e_done), .o_Error(e_err), .o_Mayoria(e_may));
`else
    comp_acum_result #(.CW(8), .WIN(4)) u_a (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Valid(i_Valid),
        .i_Mayor(i_Mayor), .i_Igual(i_Igual), .i_Menor(i_Menor), .o_CntMayor(a_m), .o_CntIgual(a_i),
        .o_CntMenor(a_l), .o_Busy(a_busy), .o_Done(a_done), .o_Error(a_err));
    comp_acum_result #(.CW(8), .WIN(3)) u_b (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Valid(i_Valid),
        .i_Mayor(i_Mayor), .i_Igual(i_Igual), .i_Menor(i_Menor), .o_CntMayor(b_m), .o_CntIgual(b_i),
        .o_CntMenor(b_l), .o_Busy(b_busy), .o_Done(b_done), .o_Error(b_err));
    comp_acum_result #(.CW(2), .WIN(5)) u_c (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Valid(i_Valid),
        .i_Mayor(i_Mayor), .i_Igual(i_Igual), .i_Menor(i_Menor), .o_CntMayor(c_m), .o_CntIgual(c_i),
        .o_CntMenor(c_l), .o_Busy(c_busy), .o_Done(c_done), .o_Error(c_err));
    comp_acum_result #(.CW(8), .WIN(8)) u_d (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Valid(i_Valid),
        .i_Mayor(i_Mayor), .i_Igual(i_Igual), .i_Menor(i_Menor), .o_CntMayor(d_m), .o_CntIgual(d_i),
        .o_CntMenor(d_l), .o_Busy(d_busy), .o_Done(d_done), .o_Error(d_err));
    comp_acum_result #(.CW(8), .WIN(1)) u_e (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Valid(i_Valid),
        .i_Mayor(i_Mayor), .i_Igual(i_Igual), .i_Menor(i_Menor), .o_CntMayor(e_m), .o_CntIgual(e_i),
        .o_CntMenor(e_l), .o_Busy(e_busy), .o_Done(e_done), .o_Error(e_err));
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic smp(input logic m, input logic i, input logic l);
        i_Valid = 1'b1;
        i_Mayor = m;
        i_Igual = i;
        i_Menor = l;
        tick();
        i_Valid = 1'b0;
        i_Mayor = 1'b0;
        i_Igual = 1'b0;
        i_Menor = 1'b0;
    endtask

    task automatic do_reset();
        i_Rst = 1'b1;
        tick();
        i_Rst = 1'b0;
    endtask

    task automatic do_start();
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_cnt", {a_m, a_i, a_l}, 24'h0);
        chk("rst_flags", {a_busy, a_done, a_err}, 3'b000);
`ifdef COMP_ACUM_MAYORIA_EN
        chk("rst_may", a_may, 2'b00);
`endif

        // Basic window WIN=4: M,M,I,m
        do_start();
        chk("basic_busy", a_busy, 1'b1);
        smp(1, 0, 0);
        smp(1, 0, 0);
        smp(0, 1, 0);
        chk("basic_no_early_done", a_done, 1'b0);
        smp(0, 0, 1);
        chk("basic_done", {a_done, a_busy}, 2'b10);
        chk("basic_cnt", {a_m, a_i, a_l}, {8'd2, 8'd1, 8'd1});
        chk("basic_err", a_err, 1'b0);
`ifdef COMP_ACUM_MAYORIA_EN
        chk("basic_may", a_may, 2'b01);
`endif
        tick();
        chk("basic_done_1cyc", {a_done, a_busy}, 2'b00);
        chk("basic_hold", {a_m, a_i, a_l}, {8'd2, 8'd1, 8'd1});

        // Gaps WIN=4: valid 1,0,0,1,1,0,1 all Igual
        do_start();
        chk("gap_clear", {a_m, a_i, a_l}, 24'h0);
`ifdef COMP_ACUM_MAYORIA_EN
        chk("gap_may_clear", a_may, 2'b00);
`endif
        smp(0, 1, 0);
        tick();
        tick();
        smp(0, 1, 0);
        smp(0, 1, 0);
        tick();
        chk("gap_no_done", {a_done, a_busy, a_i}, {1'b0, 1'b1, 8'd3});
        smp(0, 1, 0);
        chk("gap_done", a_done, 1'b1);
        chk("gap_cnt", {a_m, a_i, a_l}, {8'd0, 8'd4, 8'd0});
`ifdef COMP_ACUM_MAYORIA_EN
        chk("gap_may", a_may, 2'b11);
`endif

        // Bad samples WIN=3: {M,I}, {}, {m}
        do_reset();
        do_start();
        smp(1, 1, 0);
        chk("bad_err_set", b_err, 1'b1);
        smp(0, 0, 0);
        chk("bad_no_done", b_done, 1'b0);
        smp(0, 0, 1);
        chk("bad_done", {b_done, b_err}, 2'b11);
        chk("bad_cnt", {b_m, b_i, b_l}, {8'd0, 8'd0, 8'd1});
`ifdef COMP_ACUM_MAYORIA_EN
        chk("bad_may", b_may, 2'b10);
`endif
        tick();
        chk("bad_err_sticky", {b_err, b_done}, 2'b10);
        do_start();
        chk("bad_err_clear", b_err, 1'b0);

        // Saturation CW=2, WIN=5: 5 Mayor samples
        do_reset();
        do_start();
        for (int k = 0; k < 4; k++) smp(1, 0, 0);
        chk("sat_cnt4", {c_m, c_done}, {2'd3, 1'b0});
        smp(1, 0, 0);
        chk("sat_done", {c_m, c_done, c_err}, {2'd3, 1'b1, 1'b0});

        // Reset mid-window WIN=8, reset and start on the same edge
        do_reset();
        do_start();
        smp(1, 0, 0);
        smp(1, 0, 0);
        smp(1, 0, 0);
        chk("mid_cnt", {d_m, d_busy}, {8'd3, 1'b1});
        i_Rst = 1'b1;
        i_Start = 1'b1;
        tick();
        i_Rst = 1'b0;
        i_Start = 1'b0;
        chk("mid_rst_out", {d_m, d_i, d_l, d_busy, d_done, d_err}, 27'h0);
        tick();
        chk("mid_start_dropped", {d_busy, d_done}, 2'b00);
        do_start();
        for (int k = 0; k < 7; k++) smp(0, 1, 0);
        chk("mid_clean_nodone", {d_done, d_busy}, 2'b01);
        smp(0, 1, 0);
        chk("mid_clean_done", {d_done, d_m, d_i, d_l, d_err}, {1'b1, 8'd0, 8'd8, 8'd0, 1'b0});

        // Start held high through WIN=4 window M,m,M,m
        do_reset();
        i_Start = 1'b1;
        tick();
        smp(1, 0, 0);
        smp(0, 0, 1);
        chk("hold_no_restart", {a_m, a_l, a_busy}, {8'd1, 8'd1, 1'b1});
        smp(1, 0, 0);
        smp(0, 0, 1);
        chk("hold_done", {a_done, a_m, a_l}, {1'b1, 8'd2, 8'd2});
`ifdef COMP_ACUM_MAYORIA_EN
        chk("hold_may_tie", a_may, 2'b00);
`endif
        tick();
        chk("hold_idle", {a_done, a_busy}, 2'b00);
        tick();
        chk("hold_restart", {a_done, a_busy, a_m}, {1'b0, 1'b1, 8'd0});
        i_Start = 1'b0;

        // WIN=1: IDLE -> CONT -> FIN -> IDLE
        do_reset();
        do_start();
        chk("w1_busy", {e_busy, e_done}, 2'b10);
        smp(0, 0, 1);
        chk("w1_done", {e_busy, e_done, e_l}, {1'b0, 1'b1, 8'd1});
        tick();
        chk("w1_idle", {e_busy, e_done}, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
